// File: rtl/fb_write_arbiter_if.sv
// Write-side bundle: two requesters, clear control and the shared
// BRAM bank write fields.
interface fb_write_arbiter_if #(
    parameter int DATA_W  = 8,
    parameter int BANK_AW = 10,
    parameter int N_BANKS = 8,
    parameter int ADDR_W  = 13
);
    logic                 a_valid;
    logic                 a_ready;
    logic [ADDR_W-1:0]    a_addr;
    logic [DATA_W-1:0]    a_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [ADDR_W-1:0]    b_addr;
    logic [DATA_W-1:0]    b_data;
    logic                 clear_start;
    logic [DATA_W-1:0]    clear_value;
    logic                 clear_busy;
    logic                 clear_done;
    logic [7:0]           bank_wr_addr;
    logic [BANK_AW-9:0]   bank_wr_hi;
    logic [DATA_W-1:0]    bank_wr_data;
    logic [N_BANKS-1:0]   bank_wr_strobe;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output clear_start, clear_value,
        input  a_ready, b_ready,
        input  clear_busy, clear_done,
        input  bank_wr_addr, bank_wr_hi,
        input  bank_wr_data, bank_wr_strobe
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  clear_start, clear_value,
        output a_ready, b_ready,
        output clear_busy, clear_done,
        output bank_wr_addr, bank_wr_hi,
        output bank_wr_data, bank_wr_strobe
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin write arbiter for the framebuffer banks with a
// parallel clear engine that has priority over both requesters.
module fb_write_arbiter #(
    parameter int DATA_W  = 8,
    parameter int BANK_AW = 10,
    parameter int N_BANKS = 8,
    parameter int ADDR_W  = 13
) (
    input  logic clk,
    input  logic reset_n,
    fb_write_arbiter_if.slave bus
);
    localparam logic [BANK_AW-1:0] CNT_LAST = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state_q;
    state_t               state_d;
    logic [BANK_AW-1:0]   cnt_q;
    logic [DATA_W-1:0]    val_q;
    logic                 rr_b_q;
    logic                 done_q;
    logic [N_BANKS-1:0]   strobe_q;
    logic [7:0]           waddr_q;
    logic [BANK_AW-9:0]   hi_q;
    logic [DATA_W-1:0]    data_q;

    logic                 start;
    logic                 open;
    logic                 last;
    logic                 a_xfer;
    logic                 b_xfer;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;

    assign start  = (state_q == IDLE) && bus.clear_start;
    assign open   = (state_q == IDLE) && !bus.clear_start;
    assign last   = (cnt_q == CNT_LAST);

    // rr_b_q set means B wins the next contended cycle
    assign bus.a_ready = open && bus.a_valid &&
                         (!bus.b_valid || !rr_b_q);
    assign bus.b_ready = open && bus.b_valid &&
                         (!bus.a_valid || rr_b_q);

    assign a_xfer = bus.a_valid && bus.a_ready;
    assign b_xfer = bus.b_valid && bus.b_ready;

    assign bus.clear_busy     = (state_q == CLEAR);
    assign bus.clear_done     = done_q;
    assign bus.bank_wr_strobe = strobe_q;
    assign bus.bank_wr_addr   = waddr_q;
    assign bus.bank_wr_hi     = hi_q;
    assign bus.bank_wr_data   = data_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.clear_start) state_d = CLEAR;
            CLEAR: if (last) state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        unique case (1'b1)
            a_xfer: begin
                sel_addr = bus.a_addr;
                sel_data = bus.a_data;
            end
            b_xfer: begin
                sel_addr = bus.b_addr;
                sel_data = bus.b_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            rr_b_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == CLEAR) && last;
            if (start) begin
                cnt_q <= '0;
                val_q <= bus.clear_value;
            end else if (state_q == CLEAR) begin
                cnt_q <= cnt_q + BANK_AW'(1);
            end
            if (a_xfer)
                rr_b_q <= 1'b1;
            else if (b_xfer)
                rr_b_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q <= '0;
            waddr_q  <= '0;
            hi_q     <= '0;
            data_q   <= '0;
        end else if (state_q == CLEAR) begin
            strobe_q <= '1;
            waddr_q  <= cnt_q[7:0];
            hi_q     <= cnt_q[BANK_AW-1:8];
            data_q   <= val_q;
        end else if (a_xfer || b_xfer) begin
            strobe_q <= N_BANKS'(1) << sel_addr[ADDR_W-1:BANK_AW];
            waddr_q  <= sel_addr[7:0];
            hi_q     <= sel_addr[BANK_AW-1:8];
            data_q   <= sel_data;
        end else begin
            strobe_q <= '0;
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: model-predicted writes are
// queued with their due cycle and matched by an output monitor.
module tb_fb_write_arbiter;
    logic clk;
    logic reset_n;

    fb_write_arbiter_if bus ();

    fb_write_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] strobe;
        logic [7:0] addr;
        logic [1:0] hi;
        logic [7:0] data;
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;

    // reference model state
    int  clr_left = 0;
    int  clr_idx = 0;
    int  clr_val = 0;
    bit  done_due = 0;
    bit  last_b = 1;
    int  busy_run = 0;

    // requester-side pending transactions
    bit  a_pend = 0;
    int  a_av = 0;
    int  a_dv = 0;
    bit  b_pend = 0;
    int  b_av = 0;
    int  b_dv = 0;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic void push_req(input int a, input int d);
        wr_t e;
        e.cyc    = cyc + 1;
        e.strobe = 8'(1 << (a / 1024));
        e.addr   = 8'(a % 256);
        e.hi     = 2'((a / 256) % 4);
        e.data   = 8'(d);
        q.push_back(e);
    endfunction

    function automatic void push_clr(input int idx, input int v);
        wr_t e;
        e.cyc    = cyc + 1;
        e.strobe = 8'hFF;
        e.addr   = 8'(idx % 256);
        e.hi     = 2'(idx / 256);
        e.data   = 8'(v);
        q.push_back(e);
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        wr_t e;
        #1;
        if (bus.bank_wr_strobe != 0) begin
            if (q.size() == 0) begin
                chk("extra_write", {8'h0, bus.bank_wr_strobe}, 16'h0);
            end else begin
                e = q.pop_front();
                chk("write_cycle", 64'(cyc), 64'(e.cyc));
                chk("write",
                    {bus.bank_wr_strobe, bus.bank_wr_addr,
                     bus.bank_wr_hi, bus.bank_wr_data},
                    {e.strobe, e.addr, e.hi, e.data});
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("missing_write", 64'(0), {e.strobe, e.addr, e.data});
        end
    end

    task automatic step(input bit cs, input int cv);
        bit ga;
        bit gb;
        @(negedge clk);
        bus.a_valid     = a_pend;
        bus.a_addr      = 13'(a_av);
        bus.a_data      = 8'(a_dv);
        bus.b_valid     = b_pend;
        bus.b_addr      = 13'(b_av);
        bus.b_data      = 8'(b_dv);
        bus.clear_start = cs;
        bus.clear_value = 8'(cv);
        #1;
        chk("clear_busy", 64'(bus.clear_busy), 64'(clr_left > 0));
        chk("clear_done", 64'(bus.clear_done), 64'(done_due));
        if (bus.clear_busy) begin
            busy_run++;
        end else if (busy_run > 0) begin
            chk("busy_len", 64'(busy_run), 64'(1024));
            busy_run = 0;
        end
        ga = 0;
        gb = 0;
        if (clr_left > 0) begin
            push_clr(clr_idx, clr_val);
            clr_idx++;
            clr_left--;
            done_due = (clr_left == 0);
        end else begin
            done_due = 0;
            if (cs) begin
                clr_left = 1024;
                clr_idx  = 0;
                clr_val  = cv;
            end else if (a_pend && b_pend) begin
                ga = last_b;
                gb = !last_b;
            end else begin
                ga = a_pend;
                gb = b_pend;
            end
        end
        chk("a_ready", 64'(bus.a_ready), 64'(ga));
        chk("b_ready", 64'(bus.b_ready), 64'(gb));
        if (ga) begin
            push_req(a_av, a_dv);
            a_pend = 0;
            last_b = 0;
        end
        if (gb) begin
            push_req(b_av, b_dv);
            b_pend = 0;
            last_b = 1;
        end
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        reset_n         = 1'b0;
        bus.a_valid     = 1'b0;
        bus.b_valid     = 1'b0;
        bus.clear_start = 1'b0;
        q.delete();
        a_pend   = 0;
        b_pend   = 0;
        clr_left = 0;
        done_due = 0;
        last_b   = 1;
        busy_run = 0;
        #1;
        chk("rst_strobe", 64'(bus.bank_wr_strobe), 64'(0));
        chk("rst_addr", 64'(bus.bank_wr_addr), 64'(0));
        chk("rst_hi", 64'(bus.bank_wr_hi), 64'(0));
        chk("rst_data", 64'(bus.bank_wr_data), 64'(0));
        chk("rst_busy", 64'(bus.clear_busy), 64'(0));
        chk("rst_done", 64'(bus.clear_done), 64'(0));
        chk("rst_ready", {bus.a_ready, bus.b_ready}, 64'(0));
        repeat (hold) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_clear(input int v,
                             input int restart_at,
                             input int reset_at);
        step(1, v);
        for (int i = 0; i < 1100; i++) begin
            if (!(clr_left > 0 || done_due)) break;
            if (reset_at >= 0 && clr_idx == reset_at) begin
                do_reset(2);
                break;
            end
            step(restart_at >= 0 && clr_idx == restart_at, 8'hFF);
        end
    endtask

    int ca_addr[2] = '{32'h0123, 32'h0C44};
    int ca_data[2] = '{32'h11, 32'h22};
    int cb_addr[2] = '{32'h1A07, 32'h17FF};
    int cb_data[2] = '{32'h33, 32'h44};

    initial begin
        int na;
        int nb;
        int guard;
        reset_n         = 1'b1;
        bus.a_valid     = 1'b0;
        bus.a_addr      = '0;
        bus.a_data      = '0;
        bus.b_valid     = 1'b0;
        bus.b_addr      = '0;
        bus.b_data      = '0;
        bus.clear_start = 1'b0;
        bus.clear_value = '0;
        do_reset(3);

        // contention straight after reset: A first, then alternate
        na = 0;
        nb = 0;
        repeat (4) begin
            if (!a_pend && na < 2) begin
                a_pend = 1; a_av = ca_addr[na]; a_dv = ca_data[na];
                na++;
            end
            if (!b_pend && nb < 2) begin
                b_pend = 1; b_av = cb_addr[nb]; b_dv = cb_data[nb];
                nb++;
            end
            step(0, 0);
        end
        step(0, 0);

        a_pend = 1; a_av = 'h1C05; a_dv = 'h5A;
        step(0, 0);
        step(0, 0);
        step(0, 0);

        run_clear('h00, -1, -1);

        // clear requested as A rises; second start is ignored
        a_pend = 1; a_av = 'h0BEE; a_dv = 'hC3;
        run_clear('hA5, 500, -1);
        step(0, 0);

        run_clear('h3C, -1, 300);
        repeat (3) step(0, 0);
        run_clear('h77, -1, -1);

        repeat (3000) begin
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_pend = 1;
                a_av = $urandom_range(0, 8191);
                a_dv = $urandom_range(0, 255);
            end
            if (!b_pend && $urandom_range(0, 2) == 0) begin
                b_pend = 1;
                b_av = $urandom_range(0, 8191);
                b_dv = $urandom_range(0, 255);
            end
            step($urandom_range(0, 999) < 2, $urandom_range(0, 255));
        end

        guard = 0;
        while ((a_pend || b_pend || clr_left > 0 || done_due)
               && guard < 2200) begin
            step(0, 0);
            guard++;
        end
        chk("drain_timeout", 64'(guard < 2200), 64'(1));
        step(0, 0);
        step(0, 0);
        chk("queue_empty", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
